// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for rr_stream_mux: lock FSM state encoding and clog2 helper.
// Reused by other arbiters that need the same ARB/LOCK encoding.
package rr_stream_mux_pkg;

    typedef enum logic [0:0] {
        StArb  = 1'b0,
        StLock = 1'b1
    } lock_state_e;

    // Constant-evaluable ceil(log2(n)), minimum 1 so a 2-input mux still gets a 1-bit select.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-start priority picker: lowest requester at or above start_ptr (wrapping), or
// lowest requester overall when fixed is set. Purely combinational.
module rr_arbiter #(
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned SEL_W  = 4
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  start_ptr,
    input  logic              fixed,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [NUM_IN-1:0] w_mask_hi;
    logic [NUM_IN-1:0] w_req_hi;
    logic [NUM_IN-1:0] w_pick;

    // Requests at or above the pointer win first; if none, the wrap-around set is used.
    always_comb begin
        w_mask_hi = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_mask_hi[i] = (SEL_W'(i) >= start_ptr);
        end
        w_req_hi = req & w_mask_hi;
        w_pick   = (fixed || !(|w_req_hi)) ? req : w_req_hi;
    end

    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                gnt_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 streaming mux with round-robin / fixed-priority arbitration and a registered output.
// Define RR_STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prio_mode,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  w_in_data [NUM_IN];
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_load;
    logic [SEL_W-1:0]  w_arb_idx;
    logic              w_arb_any;
    logic [SEL_W-1:0]  w_gnt;
    logic [NUM_IN-1:0] w_in_ready;
    logic              w_xfer;
    logic              w_ptr_en;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign w_in_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .start_ptr (r_rr_ptr),
        .fixed     (prio_mode),
        .gnt_idx   (w_arb_idx),
        .gnt_any   (w_arb_any)
    );

    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_in_ready = '0;
        if (w_load && w_arb_any && !rst) begin
            w_in_ready[w_gnt] = 1'b1;
        end
    end

    assign w_xfer   = |(in_valid & w_in_ready);
    assign in_ready = w_in_ready;

`ifdef RR_STREAM_MUX_LOCK_EN
    lock_state_e      r_state;
    lock_state_e      w_state_next;
    logic [SEL_W-1:0] r_lock_idx;
    logic             w_last;

    assign w_last = in_last[w_gnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StArb;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StArb:   if (w_xfer && !w_last) w_state_next = StLock;
            StLock:  if (w_xfer && w_last)  w_state_next = StArb;
            default: w_state_next = StArb;
        endcase
    end

    // While locked the grant ignores both the arbiter and prio_mode.
    always_comb begin
        w_gnt    = (r_state == StLock) ? r_lock_idx : w_arb_idx;
        w_ptr_en = w_xfer && w_last && (!prio_mode || (r_state == StLock));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_idx <= '0;
        end else if ((r_state == StArb) && w_xfer && !w_last) begin
            r_lock_idx <= w_gnt;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^in_last;
    assign w_gnt         = w_arb_idx;
    assign w_ptr_en      = w_xfer && !prio_mode;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_in_data[w_gnt];
                r_out_sel   <= w_gnt;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_ptr_en) begin
            r_rr_ptr <= (w_gnt == SEL_W'(NUM_IN - 1)) ? '0 : w_gnt + SEL_W'(1);
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: a 16-input instance and a 5-input wrap instance.
// Expected beats are queued when stimulus is driven and compared as the DUT presents them.
module tb_rr_stream_mux;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int N5 = 5;

    typedef struct {
        logic [7:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prio_mode = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_last = '1;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic [3:0]    out_sel;
    logic          out_valid;
    logic          out_ready = 1'b1;

    logic [N5*W-1:0] in_data5 = '0;
    logic [N5-1:0] in_valid5 = '0;
    logic [N5-1:0] in_last5 = '1;
    logic [N5-1:0] in_ready5;
    logic [W-1:0]  out_data5;
    logic [2:0]    out_sel5;
    logic          out_valid5;
    logic          out_ready5 = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rr_stream_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (prio_mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_stream_mux #(.WIDTH(W), .NUM_IN(N5), .SEL_W(3)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (1'b0),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_last   (in_last5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_sel   (out_sel5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = '1;
        in_valid5 = '1;
        @(negedge clk);
        checks++;
        if (in_ready !== 16'h0) begin
            errors++;
            $display("FAIL reset_in_ready_c1 got %h want 0000", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 16'h0) begin
            errors++;
            $display("FAIL reset_in_ready_c2 got %h want 0000", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_sel !== 4'd0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_regs got sel=%0d data=%h want sel=0 data=0", out_sel, out_data);
        end
        checks++;
        if (out_valid5 !== 1'b0 || in_ready5 !== 5'h0) begin
            errors++;
            $display("FAIL reset_dut5 got valid=%b ready=%b want 0/00000", out_valid5, in_ready5);
        end
        rst = 1'b0;
        in_valid = '0;
        in_valid5 = '0;
    endtask

    task automatic test_round_robin();
        exp_t e;
        prio_mode = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(i) * 32'h11;
        in_valid = '1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 16'h0001) begin
            errors++;
            $display("FAIL rr_first_ready got %h want 0001", in_ready);
        end
        for (int k = 0; k <= N; k++) begin
            e.sel = 8'(k % N);
            e.data = 32'(k % N) * 32'h11;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== e.sel[3:0] || out_data !== e.data) begin
                errors++;
                $display("FAIL rr_beat%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         k, out_valid, out_sel, out_data, e.sel, e.data);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 16'h0) begin
            errors++;
            $display("FAIL bp_in_ready got %h want 0000", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 4'd0 || out_data !== 32'h0 || in_ready !== 16'h0)
            begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b sel=%0d data=%h rdy=%h want v=1 sel=0 data=0 rdy=0",
                         c, out_valid, out_sel, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        e.sel = 8'd1;
        e.data = 32'h11;
        sb.push_back(e);
        #1;
        checks++;
        if (in_ready !== 16'h0002) begin
            errors++;
            $display("FAIL bp_release_ready got %h want 0002", in_ready);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== e.sel[3:0] || out_data !== e.data) begin
            errors++;
            $display("FAIL bp_release got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     out_valid, out_sel, out_data, e.sel, e.data);
        end
        in_valid = '0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        prio_mode = 1'b1;
        in_valid = 16'h0208;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) in_valid = 16'h0200;
            e.sel = (c < 3) ? 8'd3 : 8'd9;
            e.data = (c < 3) ? 32'h33 : 32'h99;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== e.sel[3:0] || out_data !== e.data) begin
                errors++;
                $display("FAIL fixed_beat%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, e.sel, e.data);
            end
        end
        in_valid = '0;
        prio_mode = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fixed_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [7:0] exp_sel [3];
        exp_sel[0] = 8'd3;
        exp_sel[1] = 8'd4;
        exp_sel[2] = 8'd0;
        for (int i = 0; i < N5; i++) in_data5[i*W +: W] = 32'(i) * 32'h11;
        in_valid5 = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) in_valid5 = 5'b10001;
            e.sel = exp_sel[c];
            e.data = 32'(exp_sel[c]) * 32'h11;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (out_valid5 !== 1'b1 || out_sel5 !== e.sel[2:0] || out_data5 !== e.data) begin
                errors++;
                $display("FAIL wrap_beat%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         c, out_valid5, out_sel5, out_data5, e.sel, e.data);
            end
        end
        in_valid5 = '0;
        @(negedge clk);
        checks++;
        if (out_valid5 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain got v=%b want 0", out_valid5);
        end
    endtask

    // Channel 2 sends a 3-beat packet while channel 5 streams single-beat packets.
    task automatic test_packet_lock();
        exp_t e;
        int   beat = 0;
        int   ncyc;
        logic fire2;
`ifdef RR_STREAM_MUX_LOCK_EN
        ncyc = 4;
        e.sel = 8'd2; e.data = 32'h200; sb.push_back(e);
        e.sel = 8'd2; e.data = 32'h201; sb.push_back(e);
        e.sel = 8'd2; e.data = 32'h202; sb.push_back(e);
        e.sel = 8'd5; e.data = 32'h55;  sb.push_back(e);
`else
        ncyc = 5;
        e.sel = 8'd2; e.data = 32'h200; sb.push_back(e);
        e.sel = 8'd5; e.data = 32'h55;  sb.push_back(e);
        e.sel = 8'd2; e.data = 32'h201; sb.push_back(e);
        e.sel = 8'd5; e.data = 32'h55;  sb.push_back(e);
        e.sel = 8'd2; e.data = 32'h202; sb.push_back(e);
`endif
        prio_mode = 1'b0;
        out_ready = 1'b1;
        in_data[5*W +: W] = 32'h55;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = '0;
            in_valid[5] = 1'b1;
            in_valid[2] = (beat < 3);
            in_last = '1;
            in_last[2] = (beat == 2);
            in_data[2*W +: W] = 32'h200 + 32'(beat);
            #1;
            fire2 = in_valid[2] && in_ready[2];
            @(negedge clk);
            if (fire2) beat++;
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== e.sel[3:0] || out_data !== e.data) begin
                errors++;
                $display("FAIL lock_beat%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         c, out_valid, out_sel, out_data, e.sel, e.data);
            end
        end
        in_valid = '0;
        in_last = '1;
        @(negedge clk);
        checks++;
        if (beat != 3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_end got beats=%0d v=%b want beats=3 v=0", beat, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_wrap();
        test_packet_lock();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
